// File: rtl/ascon_block_formatter_if.sv
// -----------------------------------------------------------------------------
// ascon_block_formatter_if
// Purpose : bundles the byte-stream input handshake and the block-stream output
//           handshake of the ASCON block formatter.
// Signals : in_data_i/in_valid_i/in_last_i/in_ready_o   byte stream (valid/ready)
//           msg_empty_i                                  empty-message request
//           block_o/block_valid_o/block_ready_i/block_last_o  block stream
//           start_o, byte_count_o, err_o                 status
// Modports: slave  - the formatter (consumes bytes, produces blocks)
//           master - the environment (produces bytes, consumes blocks)
// -----------------------------------------------------------------------------
interface ascon_block_formatter_if #(
    parameter int LEN_W = 16
);
    logic [7:0]       in_data_i;
    logic             in_valid_i;
    logic             in_last_i;
    logic             in_ready_o;
    logic             msg_empty_i;
    logic [63:0]      block_o;
    logic             block_valid_o;
    logic             block_ready_i;
    logic             block_last_o;
    logic             start_o;
    logic [LEN_W-1:0] byte_count_o;
    logic             err_o;

    modport slave (
        input  in_data_i,
        input  in_valid_i,
        input  in_last_i,
        output in_ready_o,
        input  msg_empty_i,
        output block_o,
        output block_valid_o,
        input  block_ready_i,
        output block_last_o,
        output start_o,
        output byte_count_o,
        output err_o
    );

    modport master (
        output in_data_i,
        output in_valid_i,
        output in_last_i,
        input  in_ready_o,
        output msg_empty_i,
        input  block_o,
        input  block_valid_o,
        output block_ready_i,
        input  block_last_o,
        input  start_o,
        input  byte_count_o,
        input  err_o
    );
endinterface

// File: rtl/ascon_block_formatter.sv
// -----------------------------------------------------------------------------
// ascon_block_formatter
// Purpose : upstream feeder for the ASCON toplevel. Packs a plaintext byte
//           stream big-endian into 64-bit blocks, applies 10* padding
//           (PAD_BYTE then zeros) and hands blocks out one at a time with a
//           valid/ready handshake. Pulses start_o at the start of each message.
// Ports   : clock_i  - rising-edge clock
//           reset_i  - synchronous, active-high reset
//           bus      - ascon_block_formatter_if.slave (byte input, block output,
//                      start_o, byte_count_o, err_o)
// Options : ASCON_FMT_ERR_EN - when defined, err_o is a sticky protocol-error
//           flag; when undefined err_o is tied to 0 and no detection exists.
// -----------------------------------------------------------------------------
module ascon_block_formatter #(
    parameter logic [7:0] PAD_BYTE = 8'h80,
    parameter int         LEN_W    = 16
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    ascon_block_formatter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_EMIT    = 2'd2,
        ST_PAD_BLK = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [63:0]      shreg_q, shreg_d;
    logic [2:0]       pos_q, pos_d;
    logic             pad_pend_q, pad_pend_d;
    logic [63:0]      block_q, block_d;
    logic             block_valid_q, block_valid_d;
    logic             block_last_q, block_last_d;
    logic             start_q, start_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;

    logic             in_ready_s;
    logic             byte_xfer_s;
    logic             blk_xfer_s;
    logic [5:0]       byte_shift_s;
    logic [5:0]       pad_shift_s;
    logic [63:0]      merged_s;
    logic [63:0]      pad_word_s;
    logic [LEN_W-1:0] count_inc_s;

    // The ready flop resets to 1 so the formatter is ready in the first cycle
    // after reset; masking with reset_i keeps in_ready_o low while in reset.
    assign in_ready_s   = ready_q && !reset_i;
    assign byte_xfer_s  = bus.in_valid_i && in_ready_s;
    assign blk_xfer_s   = block_valid_q && bus.block_ready_i;

    // Byte lane for position pos is bits [63-8*pos -: 8]; pad lands one lane lower.
    assign byte_shift_s = 6'd56 - {pos_q, 3'b000};
    assign pad_shift_s  = 6'd48 - {pos_q, 3'b000};
    assign merged_s     = shreg_q | ({56'd0, bus.in_data_i} << byte_shift_s);
    assign pad_word_s   = {56'd0, PAD_BYTE} << pad_shift_s;

    // Saturating byte counter increment.
    assign count_inc_s  = (count_q == {LEN_W{1'b1}}) ? count_q
                                                     : count_q + {{(LEN_W-1){1'b0}}, 1'b1};

    // State register.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (byte_xfer_s) begin
                    state_d = bus.in_last_i ? ST_EMIT : ST_FILL;
                end else if (bus.msg_empty_i) begin
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (byte_xfer_s && ((pos_q == 3'd7) || bus.in_last_i)) begin
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_EMIT: begin
                if (blk_xfer_s) begin
                    if (pad_pend_q) begin
                        state_d = ST_PAD_BLK;
                    end else if (block_last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_PAD_BLK: begin
                if (blk_xfer_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PAD_BLK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        shreg_d       = shreg_q;
        pos_d         = pos_q;
        pad_pend_d    = pad_pend_q;
        block_d       = block_q;
        block_valid_d = block_valid_q;
        block_last_d  = block_last_q;
        start_d       = 1'b0;
        count_d       = count_q;
        ready_d       = (state_d == ST_IDLE) || (state_d == ST_FILL);
        case (state_q)
            ST_IDLE: begin
                if (byte_xfer_s) begin
                    // New message: count restarts at one, shreg is zero here.
                    start_d = 1'b1;
                    count_d = {{(LEN_W-1){1'b0}}, 1'b1};
                    if (bus.in_last_i) begin
                        block_d       = merged_s | pad_word_s;
                        block_valid_d = 1'b1;
                        block_last_d  = 1'b1;
                        shreg_d       = 64'd0;
                        pos_d         = 3'd0;
                    end else begin
                        shreg_d = merged_s;
                        pos_d   = 3'd1;
                    end
                end else if (bus.msg_empty_i) begin
                    start_d       = 1'b1;
                    count_d       = {LEN_W{1'b0}};
                    block_d       = {PAD_BYTE, 56'd0};
                    block_valid_d = 1'b1;
                    block_last_d  = 1'b1;
                end else begin
                    start_d = 1'b0;
                end
            end
            ST_FILL: begin
                if (byte_xfer_s) begin
                    count_d = count_inc_s;
                    if (pos_q == 3'd7) begin
                        // Full block; a last byte here needs a separate pad block.
                        block_d       = merged_s;
                        block_valid_d = 1'b1;
                        block_last_d  = 1'b0;
                        pad_pend_d    = bus.in_last_i;
                        shreg_d       = 64'd0;
                        pos_d         = 3'd0;
                    end else if (bus.in_last_i) begin
                        block_d       = merged_s | pad_word_s;
                        block_valid_d = 1'b1;
                        block_last_d  = 1'b1;
                        shreg_d       = 64'd0;
                        pos_d         = 3'd0;
                    end else begin
                        shreg_d = merged_s;
                        pos_d   = pos_q + 3'd1;
                    end
                end else begin
                    shreg_d = shreg_q;
                end
            end
            ST_EMIT: begin
                if (blk_xfer_s) begin
                    if (pad_pend_q) begin
                        // Valid stays high: the pad block follows immediately.
                        block_d       = {PAD_BYTE, 56'd0};
                        block_valid_d = 1'b1;
                        block_last_d  = 1'b1;
                        pad_pend_d    = 1'b0;
                    end else begin
                        block_valid_d = 1'b0;
                        block_last_d  = 1'b0;
                    end
                    shreg_d = 64'd0;
                    pos_d   = 3'd0;
                end else begin
                    block_valid_d = 1'b1;
                end
            end
            ST_PAD_BLK: begin
                if (blk_xfer_s) begin
                    block_valid_d = 1'b0;
                    block_last_d  = 1'b0;
                end else begin
                    block_valid_d = 1'b1;
                end
            end
            default: begin
                block_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            shreg_q       <= 64'd0;
            pos_q         <= 3'd0;
            pad_pend_q    <= 1'b0;
            block_q       <= 64'd0;
            block_valid_q <= 1'b0;
            block_last_q  <= 1'b0;
            start_q       <= 1'b0;
            count_q       <= {LEN_W{1'b0}};
            ready_q       <= 1'b1;
        end else begin
            shreg_q       <= shreg_d;
            pos_q         <= pos_d;
            pad_pend_q    <= pad_pend_d;
            block_q       <= block_d;
            block_valid_q <= block_valid_d;
            block_last_q  <= block_last_d;
            start_q       <= start_d;
            count_q       <= count_d;
            ready_q       <= ready_d;
        end
    end

    assign bus.in_ready_o    = in_ready_s;
    assign bus.block_o       = block_q;
    assign bus.block_valid_o = block_valid_q;
    assign bus.block_last_o  = block_last_q;
    assign bus.start_o       = start_q;
    assign bus.byte_count_o  = count_q;

`ifdef ASCON_FMT_ERR_EN
    logic err_q, err_d;
    logic offer_q, offer_d;

    // Protocol error detection; offer_q remembers a byte offered during a stall.
    always_comb begin
        offer_d = block_valid_q && bus.in_valid_i && !blk_xfer_s;
        err_d   = err_q
                | (bus.msg_empty_i && (state_q != ST_IDLE))
                | (bus.msg_empty_i && byte_xfer_s)
                | (offer_q && block_valid_q && !bus.in_valid_i);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            err_q   <= 1'b0;
            offer_q <= 1'b0;
        end else begin
            err_q   <= err_d;
            offer_q <= offer_d;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

endmodule
